fl_frame_checker: RTL and testbench
===================================

# fl_frame_checker

Synthesizable FrameLink sink for the receive end of a FrameLink stream, such as the TX port of the asynchronous FL FIFO. It drives `RX_DST_RDY_N` with LFSR-based throttling and checks frame and packet framing. It measures the byte length of each packet and counts good frames and protocol errors. It is the hardware counterpart of the bench FL driver and serves for on-chip self-test and hardware-in-loop runs.

## Interface
Parameters:
- DATA_WIDTH, 64, FL data width in bits; power of two, 8..256.
- DREM_WIDTH, 3, equals log2(DATA_WIDTH/8).
- PACKET_COUNT, 3, required packets per frame; 1..15.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- CLK, in, 1, clock.
- RESET_N, in, 1, asynchronous reset, active-low; one clock domain only.
- RX_DATA, in, DATA_WIDTH, FL data; not checked.
- RX_REM, in, DREM_WIDTH, index of the last valid byte; meaningful only on the EOP word.
- RX_SOF_N / RX_EOF_N / RX_SOP_N / RX_EOP_N, in, 1 each, FL delimiters, active-low.
- RX_SRC_RDY_N, in, 1, source ready, active-low.
- RX_DST_RDY_N, out, 1, destination ready, active-low, registered.
- THROTTLE, in, 4, stall weight; 0 means always ready, 15 means ready 1/16 of cycles.
- CLR, in, 1, synchronous clear of counters and error flags.
- PKT_LEN, out, 16, byte length of the last completed packet.
- PKT_LEN_VLD, out, 1, one-cycle pulse when PKT_LEN updates.
- FRAME_CNT, out, 32, count of error-free frames, wraps.
- ERR_CNT, out, 16, count of errors, saturates at 16'hFFFF.
- ERROR, out, 1, sticky error flag.
- ERR_CODE, out, 3, code of the first error since reset or CLR.

## Operation
- Transfer (xfer) = !RX_SRC_RDY_N && !RX_DST_RDY_N. All checks evaluate only on xfer cycles.
- FSM states:
  - IDLE: outside a frame.
  - IN_PKT: inside a packet.
  - GAP: inside a frame, between packets.
- IDLE:
  - SOF+SOP xfer goes to IN_PKT. It sets pkt_idx=1 and word_cnt=1.
  - Any other xfer is err 2 (word outside frame). The word is dropped and the state stays IDLE.
- IN_PKT:
  - Each xfer increments word_cnt.
  - EOP completes the packet. Byte length = (word_cnt-1)*(DATA_WIDTH/8)+RX_REM+1, saturated at 16'hFFFF.
  - EOP without EOF goes to GAP.
  - EOP with EOF goes to IDLE. The frame is good if pkt_idx==PACKET_COUNT and no error occurred in this frame; otherwise err 5.
  - SOP without SOF is err 3. The current packet is abandoned and a new packet starts with pkt_idx+1.
  - EOF without EOP is err 4. The frame is abandoned and the state goes to IDLE.
- GAP:
  - SOP xfer goes to IN_PKT with pkt_idx+1. If pkt_idx exceeds PACKET_COUNT, raise err 5 at the EOF.
  - A non-SOP xfer is err 6. The word is dropped and the state stays GAP.
- SOF in IN_PKT or GAP is err 1. The old frame is aborted and not counted. The word starts a new frame as if the state were IDLE.
- One word can carry SOF+SOP+EOP+EOF. That is a 1-packet frame of RX_REM+1 bytes.
- Error codes: 1 SOF inside frame, 2 word outside frame, 3 SOP inside packet, 4 EOF without EOP, 5 packet count mismatch, 6 non-SOP word in gap.
  - When several errors hit on one word, the lowest code counts, once.
  - ERR_CNT increments by 1 per errored word.
  - ERR_CODE latches only while ERROR=0.
- Throttle uses a Fibonacci LFSR x^16+x^14+x^13+x^11+1 that advances every cycle.
  - RX_DST_RDY_N <= (lfsr[3:0] < THROTTLE).
- CLR zeroes FRAME_CNT, ERR_CNT, ERROR and ERR_CODE. It does not affect the FSM, the LFSR, or PKT_LEN.
  - If CLR coincides with a frame-count or error event, CLR wins and the event is lost.

## Timing
- Reset values:
  - RX_DST_RDY_N=1, PKT_LEN=0, PKT_LEN_VLD=0.
  - FRAME_CNT=0, ERR_CNT=0, ERROR=0, ERR_CODE=0.
  - FSM in IDLE, LFSR at LFSR_SEED.
- With THROTTLE=0, RX_DST_RDY_N goes 0 at the first CLK edge after RESET_N deasserts.
- RX_DST_RDY_N does not depend combinationally on RX_SRC_RDY_N.
- PKT_LEN and PKT_LEN_VLD are valid one cycle after the EOP xfer.
- FRAME_CNT, ERR_CNT, ERROR and ERR_CODE update one cycle after the causing xfer.
- FRAME_CNT wraps from 32'hFFFFFFFF to 0.
- Reset asserted mid-frame immediately returns every output to its reset value. The partial frame is neither counted nor flagged.
- Non-xfer cycles change no state except the LFSR.

## Test plan
- THROTTLE=0, 100 frames of 3 packets with lengths 128/1536/128 bytes -> FRAME_CNT=100, ERR_CNT=0, PKT_LEN pulses 128,1536,128 repeating, RX_DST_RDY_N=0 continuously.
- Single word with SOF+SOP+EOP+EOF and RX_REM=0, with PACKET_COUNT=1 (separate elaboration) -> PKT_LEN=1, FRAME_CNT=1.
- Frame with only 2 packets -> ERR_CODE=5, ERR_CNT=1, FRAME_CNT unchanged; the next valid frame gives FRAME_CNT+1.
- SOF arrives in GAP after packet 1 -> ERR_CODE=1; the new frame, if well formed, is counted; a word outside a frame -> ERR_CNT=2, ERR_CODE stays 1; then CLR -> all four counters and flags are 0.
- THROTTLE=8, 2000 random frames, with the source asserting RX_SRC_RDY_N with random gaps -> RX_DST_RDY_N=1 on about 50% of cycles, FRAME_CNT=2000, ERR_CNT=0, every PKT_LEN matches the sent length.
- RESET_N pulsed low in the middle of packet 2 -> all outputs at reset values on the same edge; the next full frame gives FRAME_CNT=1, ERROR=0.

Source files
------------

// File: rtl/fl_frame_checker.sv
// FrameLink sink: throttles RX_DST_RDY_N from an LFSR, checks SOF/SOP/EOP/EOF framing,
// reports per-packet byte length and counts good frames and protocol errors.
module fl_frame_checker #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned DREM_WIDTH   = 3,
  parameter int unsigned PACKET_COUNT = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [DREM_WIDTH-1:0] RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  input  logic [3:0]            THROTTLE,
  input  logic                  CLR,
  output logic [15:0]           PKT_LEN,
  output logic                  PKT_LEN_VLD,
  output logic [31:0]           FRAME_CNT,
  output logic [15:0]           ERR_CNT,
  output logic                  ERROR,
  output logic [2:0]            ERR_CODE
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, IN_PKT, GAP} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   pkt_idx, pkt_idx_nx, idx_now, idx_inc;
  logic [CNT_W-1:0]   word_cnt, word_cnt_nx, cnt_now, cnt_inc;
  logic               frame_err, frame_err_nx, ferr_now;
  logic [15:0]        lfsr;
  logic               lfsr_fb;

  logic               xfer, sof, sop, eop, eof;
  logic               pkt_word;
  logic               e1, e2, e3, e4, e5, e6;
  logic               err_c, frame_ok_c, len_vld_c;
  logic [2:0]         code_c;
  logic [31:0]        len_full;
  logic [15:0]        len_c;
  logic               unused_data;

  assign unused_data = ^RX_DATA;

  assign xfer = !RX_SRC_RDY_N && !RX_DST_RDY_N;
  assign sof  = !RX_SOF_N;
  assign sop  = !RX_SOP_N;
  assign eop  = !RX_EOP_N;
  assign eof  = !RX_EOF_N;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign idx_inc = (pkt_idx == '1) ? pkt_idx : pkt_idx + IDX_W'(1);
  assign cnt_inc = (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);

  // Framing decode: a SOF inside a frame aborts it and is then handled as in IDLE
  always_comb begin
    state_nx     = state;
    pkt_idx_nx   = pkt_idx;
    word_cnt_nx  = word_cnt;
    frame_err_nx = frame_err;
    pkt_word     = 1'b0;
    cnt_now      = word_cnt;
    idx_now      = pkt_idx;
    ferr_now     = frame_err;
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; e4 = 1'b0; e5 = 1'b0; e6 = 1'b0;
    frame_ok_c   = 1'b0;
    len_vld_c    = 1'b0;

    if (xfer) begin
      if (sof && (state != IDLE)) e1 = 1'b1;

      if (sof || (state == IDLE)) begin
        if (sof && sop) begin
          pkt_word = 1'b1;
          cnt_now  = CNT_W'(1);
          idx_now  = IDX_W'(1);
          ferr_now = 1'b0;
        end else begin
          e2       = 1'b1;
          state_nx = IDLE;
        end
      end else if (state == IN_PKT) begin
        pkt_word = 1'b1;
        if (sop) begin
          e3       = 1'b1;
          cnt_now  = CNT_W'(1);
          idx_now  = idx_inc;
          ferr_now = 1'b1;
        end else begin
          cnt_now  = cnt_inc;
        end
      end else begin
        if (sop) begin
          pkt_word = 1'b1;
          cnt_now  = CNT_W'(1);
          idx_now  = idx_inc;
        end else begin
          e6           = 1'b1;
          frame_err_nx = 1'b1;
        end
      end

      if (pkt_word) begin
        pkt_idx_nx   = idx_now;
        word_cnt_nx  = cnt_now;
        frame_err_nx = ferr_now;
        if (eop) begin
          len_vld_c = 1'b1;
          if (eof) begin
            state_nx = IDLE;
            if ((idx_now == IDX_W'(PACKET_COUNT)) && !ferr_now) frame_ok_c = 1'b1;
            else e5 = 1'b1;
          end else begin
            state_nx = GAP;
          end
        end else if (eof) begin
          e4       = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = IN_PKT;
        end
      end
    end

    if (e1)      code_c = 3'd1;
    else if (e2) code_c = 3'd2;
    else if (e3) code_c = 3'd3;
    else if (e4) code_c = 3'd4;
    else if (e5) code_c = 3'd5;
    else if (e6) code_c = 3'd6;
    else         code_c = 3'd0;
    err_c = e1 | e2 | e3 | e4 | e5 | e6;

    len_full = 32'(cnt_now - CNT_W'(1)) * 32'(BYTES) + 32'(RX_REM) + 32'd1;
    len_c    = (len_full > 32'h0000_FFFF) ? 16'hFFFF : len_full[15:0];
  end

  // State, throttle and status registers; CLR overrides same-cycle count/error events
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      pkt_idx      <= '0;
      word_cnt     <= '0;
      frame_err    <= 1'b0;
      lfsr         <= LFSR_SEED;
      RX_DST_RDY_N <= 1'b1;
      PKT_LEN      <= '0;
      PKT_LEN_VLD  <= 1'b0;
      FRAME_CNT    <= '0;
      ERR_CNT      <= '0;
      ERROR        <= 1'b0;
      ERR_CODE     <= '0;
    end else begin
      state        <= state_nx;
      pkt_idx      <= pkt_idx_nx;
      word_cnt     <= word_cnt_nx;
      frame_err    <= frame_err_nx;
      lfsr         <= {lfsr[14:0], lfsr_fb};
      RX_DST_RDY_N <= (lfsr[3:0] < THROTTLE);
      PKT_LEN_VLD  <= len_vld_c;
      if (len_vld_c) PKT_LEN <= len_c;
      if (CLR) begin
        FRAME_CNT <= '0;
        ERR_CNT   <= '0;
        ERROR     <= 1'b0;
        ERR_CODE  <= '0;
      end else begin
        if (frame_ok_c) FRAME_CNT <= FRAME_CNT + 32'd1;
        if (err_c) begin
          if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
          if (!ERROR) begin
            ERROR    <= 1'b1;
            ERR_CODE <= code_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fl_frame_checker.sv
// Directed bench for fl_frame_checker: vector table for framing/error sequences plus
// streaming, throttled random-frame and mid-frame reset scenarios.
module tb_fl_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_data;
  logic [2:0]  rx_rem;
  logic        sof_n, eof_n, sop_n, eop_n, src_rdy_n;
  logic [3:0]  throttle;
  logic        clr;

  logic        dst_rdy_n, pkt_len_vld, error;
  logic [15:0] pkt_len, err_cnt;
  logic [31:0] frame_cnt;
  logic [2:0]  err_code;

  logic        dst_rdy_n1, pkt_len_vld1, error1;
  logic [15:0] pkt_len1, err_cnt1;
  logic [31:0] frame_cnt1;
  logic [2:0]  err_code1;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int cyc = 0;
  int hi = 0;
  bit mon_en = 1'b0;
  bit cnt_en = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_len;

  always #5 clk = ~clk;

  fl_frame_checker #(.DATA_WIDTH(64), .DREM_WIDTH(3), .PACKET_COUNT(3), .LFSR_SEED(16'hACE1)) dut (
    .CLK(clk), .RESET_N(rst_n), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_EOF_N(eof_n), .RX_SOP_N(sop_n), .RX_EOP_N(eop_n),
    .RX_SRC_RDY_N(src_rdy_n), .RX_DST_RDY_N(dst_rdy_n), .THROTTLE(throttle), .CLR(clr),
    .PKT_LEN(pkt_len), .PKT_LEN_VLD(pkt_len_vld), .FRAME_CNT(frame_cnt),
    .ERR_CNT(err_cnt), .ERROR(error), .ERR_CODE(err_code)
  );

  fl_frame_checker #(.DATA_WIDTH(64), .DREM_WIDTH(3), .PACKET_COUNT(1), .LFSR_SEED(16'hACE1)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_EOF_N(eof_n), .RX_SOP_N(sop_n), .RX_EOP_N(eop_n),
    .RX_SRC_RDY_N(src_rdy_n), .RX_DST_RDY_N(dst_rdy_n1), .THROTTLE(throttle), .CLR(clr),
    .PKT_LEN(pkt_len1), .PKT_LEN_VLD(pkt_len_vld1), .FRAME_CNT(frame_cnt1),
    .ERR_CNT(err_cnt1), .ERROR(error1), .ERR_CODE(err_code1)
  );

  typedef struct {
    logic        clr;
    logic [3:0]  dl;     // {sof, sop, eop, eof}, active-high
    logic [2:0]  rem;
    logic        vld;
    logic [15:0] len;
    logic [31:0] frame;
    logic [15:0] ecnt;
    logic        err;
    logic [2:0]  code;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic c, input logic [3:0] dl, input logic [2:0] rem,
                              input logic vld, input logic [15:0] len, input logic [31:0] frame,
                              input logic [15:0] ecnt, input logic err, input logic [2:0] code);
    vec_t v;
    v.clr = c; v.dl = dl; v.rem = rem; v.vld = vld; v.len = len;
    v.frame = frame; v.ecnt = ecnt; v.err = err; v.code = code;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [3:0] dl, input logic [2:0] rem, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    {sof_n, sop_n, eop_n, eof_n} = ~dl;
    rx_rem    = rem;
    rx_data   = {$urandom, $urandom};
    src_rdy_n = 1'b0;
    while (dst_rdy_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dst_rdy_n) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: dst_rdy_n still 1 after %0d cycles, required 0", n);
    end
    @(posedge clk);
    #1;
    src_rdy_n = 1'b1;
  endtask

  task automatic send_packet(input bit first, input bit last, input int nbytes, input int gapmax);
    int words;
    logic [2:0] rem;
    logic [3:0] dl;
    words = (nbytes + 7) / 8;
    rem   = 3'((nbytes - 1) % 8);
    for (int w = 0; w < words; w++) begin
      dl = {first && (w == 0), w == 0, w == words - 1, last && (w == words - 1)};
      if (w == words - 1) exp_q.push_back(16'(nbytes));
      send_word(dl, (w == words - 1) ? rem : 3'd0,
                (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    end
  endtask

  task automatic send_frame(input int l0, input int l1, input int l2, input int gapmax);
    send_packet(1'b1, 1'b0, l0, gapmax);
    send_packet(1'b0, 1'b0, l1, gapmax);
    send_packet(1'b0, 1'b1, l2, gapmax);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dst_rdy_n"}, 32'(dst_rdy_n), 32'd1);
    check({tag, "_pkt_len"}, 32'(pkt_len), 32'd0);
    check({tag, "_pkt_len_vld"}, 32'(pkt_len_vld), 32'd0);
    check({tag, "_frame_cnt"}, frame_cnt, 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  // PKT_LEN scoreboard and ready-duty counter
  always @(negedge clk) begin
    if (mon_en && pkt_len_vld) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pkt_len_unexpected: got %0d, no packet pending", pkt_len);
      end else begin
        exp_len = exp_q.pop_front();
        check("pkt_len_stream", 32'(pkt_len), 32'(exp_len));
      end
    end
    if (cnt_en) begin
      cyc++;
      if (dst_rdy_n) hi++;
    end
  end

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_rem = '0;
    sof_n = 1'b1; eof_n = 1'b1; sop_n = 1'b1; eop_n = 1'b1; src_rdy_n = 1'b1;
    throttle = 4'd0; clr = 1'b0;

    tbl[0]  = mk(1'b0, 4'b1100, 3'd0, 1'b0, 16'd1,  32'd0, 16'd0, 1'b0, 3'd0);
    tbl[1]  = mk(1'b0, 4'b0010, 3'd3, 1'b1, 16'd12, 32'd0, 16'd0, 1'b0, 3'd0);
    tbl[2]  = mk(1'b0, 4'b0111, 3'd7, 1'b1, 16'd8,  32'd0, 16'd1, 1'b1, 3'd5);
    tbl[3]  = mk(1'b0, 4'b1110, 3'd0, 1'b1, 16'd1,  32'd0, 16'd1, 1'b1, 3'd5);
    tbl[4]  = mk(1'b0, 4'b0100, 3'd0, 1'b0, 16'd1,  32'd0, 16'd1, 1'b1, 3'd5);
    tbl[5]  = mk(1'b0, 4'b0000, 3'd0, 1'b0, 16'd1,  32'd0, 16'd1, 1'b1, 3'd5);
    tbl[6]  = mk(1'b0, 4'b0010, 3'd5, 1'b1, 16'd22, 32'd0, 16'd1, 1'b1, 3'd5);
    tbl[7]  = mk(1'b0, 4'b0111, 3'd2, 1'b1, 16'd3,  32'd1, 16'd1, 1'b1, 3'd5);
    tbl[8]  = mk(1'b1, 4'b0000, 3'd0, 1'b0, 16'd3,  32'd0, 16'd0, 1'b0, 3'd0);
    tbl[9]  = mk(1'b0, 4'b1110, 3'd7, 1'b1, 16'd8,  32'd0, 16'd0, 1'b0, 3'd0);
    tbl[10] = mk(1'b0, 4'b1110, 3'd0, 1'b1, 16'd1,  32'd0, 16'd1, 1'b1, 3'd1);
    tbl[11] = mk(1'b0, 4'b0110, 3'd1, 1'b1, 16'd2,  32'd0, 16'd1, 1'b1, 3'd1);
    tbl[12] = mk(1'b0, 4'b0111, 3'd3, 1'b1, 16'd4,  32'd1, 16'd1, 1'b1, 3'd1);
    tbl[13] = mk(1'b0, 4'b0000, 3'd0, 1'b0, 16'd4,  32'd1, 16'd2, 1'b1, 3'd1);
    tbl[14] = mk(1'b1, 4'b0000, 3'd0, 1'b0, 16'd4,  32'd0, 16'd0, 1'b0, 3'd0);
    tbl[15] = mk(1'b0, 4'b1100, 3'd0, 1'b0, 16'd4,  32'd0, 16'd0, 1'b0, 3'd0);
    tbl[16] = mk(1'b0, 4'b0100, 3'd0, 1'b0, 16'd4,  32'd0, 16'd1, 1'b1, 3'd3);
    tbl[17] = mk(1'b0, 4'b0001, 3'd0, 1'b0, 16'd4,  32'd0, 16'd2, 1'b1, 3'd3);
    tbl[18] = mk(1'b0, 4'b1110, 3'd0, 1'b1, 16'd1,  32'd0, 16'd2, 1'b1, 3'd3);
    tbl[19] = mk(1'b0, 4'b0010, 3'd0, 1'b0, 16'd1,  32'd0, 16'd3, 1'b1, 3'd3);
    tbl[20] = mk(1'b0, 4'b0110, 3'd0, 1'b1, 16'd1,  32'd0, 16'd3, 1'b1, 3'd3);
    tbl[21] = mk(1'b0, 4'b0111, 3'd0, 1'b1, 16'd1,  32'd0, 16'd4, 1'b1, 3'd3);

    // Reset values and first ready edge
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("rdy_before_edge", 32'(dst_rdy_n), 32'd1);
    @(posedge clk);
    #1;
    check("rdy_first_edge", 32'(dst_rdy_n), 32'd0);

    // Single-word frame: good for PACKET_COUNT=1, count mismatch for PACKET_COUNT=3
    send_word(4'b1111, 3'd0, 0);
    check("pc1_pkt_len", 32'(pkt_len1), 32'd1);
    check("pc1_pkt_len_vld", 32'(pkt_len_vld1), 32'd1);
    check("pc1_frame_cnt", frame_cnt1, 32'd1);
    check("pc1_err_cnt", 32'(err_cnt1), 32'd0);
    check("pc3_pkt_len", 32'(pkt_len), 32'd1);
    check("pc3_err_code", 32'(err_code), 32'd5);
    check("pc3_frame_cnt", frame_cnt, 32'd0);
    do_clr();
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_error", 32'(error), 32'd0);
    check("clr_err_code", 32'(err_code), 32'd0);
    check("clr_pc1_frame_cnt", frame_cnt1, 32'd0);

    // Framing/error vector table
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].clr) do_clr();
      else send_word(tbl[i].dl, tbl[i].rem, 0);
      check($sformatf("v%0d_pkt_len_vld", i), 32'(pkt_len_vld), 32'(tbl[i].vld));
      check($sformatf("v%0d_pkt_len", i), 32'(pkt_len), 32'(tbl[i].len));
      check($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].frame);
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ecnt));
      check($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].err));
      check($sformatf("v%0d_err_code", i), 32'(err_code), 32'(tbl[i].code));
    end

    // Full-rate stream of 128/1536/128-byte frames
    do_clr();
    mon_en = 1'b1; pulses = 0; hi = 0; cyc = 0; cnt_en = 1'b1;
    for (int f = 0; f < 100; f++) send_frame(128, 1536, 128, 0);
    repeat (2) @(negedge clk);
    #1;
    cnt_en = 1'b0;
    check("stream_frame_cnt", frame_cnt, 32'd100);
    check("stream_err_cnt", 32'(err_cnt), 32'd0);
    check("stream_rdy_busy_cycles", 32'(hi), 32'd0);
    check("stream_pulses", 32'(pulses), 32'd300);
    check("stream_queue_left", 32'(exp_q.size()), 32'd0);

    // Throttled random frames with source gaps
    do_clr();
    throttle = 4'd8; pulses = 0; hi = 0; cyc = 0; cnt_en = 1'b1;
    for (int f = 0; f < 2000; f++)
      send_frame(int'($urandom_range(16, 1)), int'($urandom_range(16, 1)),
                 int'($urandom_range(16, 1)), 2);
    repeat (2) @(negedge clk);
    #1;
    cnt_en = 1'b0;
    check("rand_frame_cnt", frame_cnt, 32'd2000);
    check("rand_err_cnt", 32'(err_cnt), 32'd0);
    check("rand_pulses", 32'(pulses), 32'd6000);
    check("rand_queue_left", 32'(exp_q.size()), 32'd0);
    checks++;
    if (cyc == 0 || hi * 100 < cyc * 35 || hi * 100 > cyc * 65) begin
      failures++;
      $display("FAIL rdy_duty: busy %0d of %0d cycles, required 35..65 percent", hi, cyc);
    end

    // Asynchronous reset in the middle of packet 2
    throttle = 4'd0;
    send_packet(1'b1, 1'b0, 20, 0);
    send_word(4'b0100, 3'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8, 16, 24, 0);
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_frame_cnt", frame_cnt, 32'd1);
    check("post_rst_error", 32'(error), 32'd0);
    check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("post_rst_queue_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
